// File: rtl/arith_result_collector.sv
// Tracks in-flight operand sets through the fixed-latency arithmetic pipeline, captures each Y,
// rounds/saturates it and buffers it in a fall-through FIFO; credits stop issue before the FIFO could overflow.
module arith_result_collector #(
  parameter int LATENCY = 7,
  parameter int IN_W    = 36,
  parameter int SHIFT   = 12,
  parameter int OUT_W   = 18,
  parameter int DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  y,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_sticky,
  input  logic                    sat_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [IN_W:0]    SAT_MAX = {{(IN_W+1-OUT_W){1'b0}}, OUT_MAX};
  localparam logic signed [IN_W:0]    SAT_MIN = {{(IN_W+1-OUT_W){1'b1}}, OUT_MIN};

  logic [LATENCY-1:0]       vpipe;
  logic [LATENCY-1:0]       vpipe_nxt;
  logic [CW-1:0]            occ;
  logic [CW-1:0]            count;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic signed [OUT_W-1:0]  mem [DEPTH];
  logic signed [OUT_W-1:0]  hold;
  logic signed [OUT_W-1:0]  sat_val;
  logic signed [IN_W:0]     y_ext;
  logic signed [IN_W:0]     r;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     sat_hi;
  logic                     sat_lo;

  assign ce        = en;
  assign in_ready  = rst_n & (occ < CW'(DEPTH));
  assign accept    = in_valid & in_ready & en;
  // Gate with en so a result parked at the last stage while en is low pushes only once.
  assign push      = vpipe[LATENCY-1] & en;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    vpipe_nxt    = vpipe << 1;
    vpipe_nxt[0] = accept;
  end

  assign y_ext = {y[IN_W-1], y};

  generate
    if (SHIFT == 0) begin : g_noround
      assign r = y_ext;
    end else begin : g_round
      localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
      logic signed [IN_W:0] sum;
      // One extra bit of headroom keeps the half-LSB add from wrapping at the top of range.
      assign sum = y_ext + HALF;
      assign r   = sum >>> SHIFT;
    end
  endgenerate

  assign sat_hi  = (r > SAT_MAX);
  assign sat_lo  = (r < SAT_MIN);
  assign sat_val = sat_hi ? OUT_MAX : (sat_lo ? OUT_MIN : r[OUT_W-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe      <= '0;
      occ        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold       <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (en) vpipe <= vpipe_nxt;

      case ({accept, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: ;
      endcase

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= mem[rd_ptr];
      end

      if (push && (sat_hi || sat_lo)) sat_sticky <= 1'b1;
      else if (sat_clr)               sat_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sat_val;
  end

  // Empty FIFO keeps presenting the last popped value.
  assign out_data = out_valid ? mem[rd_ptr] : hold;

endmodule

// File: tb/tb_arith_result_collector.sv
// Bench: models the arithmetic pipeline as an en-gated delay line of Y values and predicts
// every collector output from issue order, rounding rules and credit limits.
module tb_arith_result_collector;
  localparam int LAT   = 7;
  localparam int IN_W  = 36;
  localparam int SHIFT = 12;
  localparam int OUT_W = 18;
  localparam int DEPTH = 8;

  localparam longint ONE  = longint'(1) << SHIFT;
  localparam longint HALF = ONE / 2;
  localparam longint OMAX = (longint'(1) << (OUT_W-1)) - 1;
  localparam longint OMIN = -OMAX - 1;
  localparam longint YMAX = (longint'(1) << (IN_W-1)) - 1;
  localparam longint YMIN = -YMAX - 1;

  logic clk = 1'b0;
  logic rst_n, en, ce, in_valid, in_ready, out_valid, out_ready, sat_sticky, sat_clr;
  logic signed [IN_W-1:0]  y;
  logic signed [OUT_W-1:0] out_data;

  int tests = 0;
  int fails = 0;

  longint env_y [LAT];
  bit     mv    [LAT];
  longint fifo_q[$];
  longint pop_log[$];
  longint hold_m;
  bit     sticky_m;
  bit     a;
  int     k;

  always #5 clk = ~clk;

  always_comb y = IN_W'(env_y[LAT-1]);

  arith_result_collector #(
    .LATENCY(LAT), .IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_sticky(sat_sticky), .sat_clr(sat_clr)
  );

  function automatic longint unclamped(input longint v);
    longint s, q;
    s = v + HALF;
    q = s / ONE;
    if ((s % ONE) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint model_out(input longint v);
    longint q;
    q = unclamped(v);
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
    return q;
  endfunction

  function automatic bit model_sat(input longint v);
    longint q;
    q = unclamped(v);
    return (q > OMAX) || (q < OMIN);
  endfunction

  function automatic longint rand36();
    longint v;
    v = longint'({$urandom, $urandom});
    return v >>> (64 - IN_W);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, check model vs DUT, advance both across the edge. Starts and ends at negedge.
  task automatic step(input bit r, input bit e, input bit iv, input bit ordy, input bit sclr,
                      input longint yv, output bit acc);
    bit exp_rdy, push, sat, pop;
    longint pv;
    int inflight;
    rst_n = r; en = e; in_valid = iv; out_ready = ordy; sat_clr = sclr;
    #1;
    inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(mv[i]);
    exp_rdy = r && ((inflight + fifo_q.size()) < DEPTH);
    chk("ce", longint'(ce), longint'(e));
    chk("in_ready", longint'(in_ready), longint'(exp_rdy));
    chk("out_valid", longint'(out_valid), longint'(fifo_q.size() != 0));
    chk("out_data", longint'(out_data), (fifo_q.size() != 0) ? fifo_q[0] : hold_m);
    chk("sat_sticky", longint'(sat_sticky), longint'(sticky_m));
    acc  = iv && exp_rdy && e;
    push = mv[LAT-1] && e;
    pv   = model_out(env_y[LAT-1]);
    sat  = model_sat(env_y[LAT-1]);
    pop  = (fifo_q.size() != 0) && ordy;
    if (out_valid && ordy) pop_log.push_back(longint'(out_data));
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
      fifo_q.delete();
      hold_m   = 0;
      sticky_m = 1'b0;
    end else begin
      if (pop) hold_m = fifo_q.pop_front();
      if (push) fifo_q.push_back(pv);
      if (push && sat) sticky_m = 1'b1;
      else if (sclr)   sticky_m = 1'b0;
      if (e) begin
        for (int i = LAT-1; i > 0; i--) mv[i] = mv[i-1];
        mv[0] = acc;
      end
    end
    // The arithmetic pipeline has no reset and advances on ce alone.
    if (e) begin
      for (int i = LAT-1; i > 0; i--) env_y[i] = env_y[i-1];
      env_y[0] = acc ? yv : rand36();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit e, input bit ordy);
    bit x;
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, ordy, 1'b0, 0, x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint rv [5];
    longint ev [5];
    longint yv;
    bit r, e, iv, ordy, sclr;

    rv = '{-6144, -2049, -2048, 2047, 2048};
    ev = '{-1, -1, 0, 0, 1};

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    for (int i = 0; i < LAT; i++) begin env_y[i] = 0; mv[i] = 1'b0; end
    hold_m = 0; sticky_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Hand-computed pins on the rounding model itself.
    chk("pin_6144", model_out(6144), 2);
    for (int i = 0; i < 5; i++) chk("pin_round", model_out(rv[i]), ev[i]);
    chk("pin_max", model_out(YMAX), 131071);
    chk("pin_min", model_out(YMIN), -131072);

    // Single sample: push on the 7th ce edge after the accept.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6144, a);
    idle(6, 1'b1, 1'b0);
    chk("t1_not_yet", longint'(out_valid), 0);
    idle(1, 1'b1, 1'b0);
    chk("t1_valid", longint'(out_valid), 1);
    chk("t1_data", longint'(out_data), 2);
    chk("t1_sticky", longint'(sat_sticky), 0);
    idle(2, 1'b1, 1'b1);

    // Rounding of negatives and ties.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rv[i], a);
    idle(8, 1'b1, 1'b0);
    pop_log.delete();
    idle(6, 1'b1, 1'b1);
    chk("t2_count", pop_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++) chk("t2_val", pop_log[i], ev[i]);

    // Saturation and sticky flag.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, YMAX, a);
    idle(7, 1'b1, 1'b0);
    chk("t3_max", longint'(out_data), 131071);
    chk("t3_sticky", longint'(sat_sticky), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, YMIN, a);
    idle(7, 1'b1, 1'b0);
    chk("t3_min", longint'(out_data), -131072);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, a);
    chk("t3_clr", longint'(sat_sticky), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, YMAX, a);
    idle(6, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, a);
    chk("t3_set_wins", longint'(sat_sticky), 1);
    idle(2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, a);
    idle(4, 1'b1, 1'b1);

    // Backpressure: credits stop issue at DEPTH outstanding.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, longint'(100 + k) * ONE, a);
      if (a) k++;
    end
    chk("t4_accepts", k, 8);
    chk("t4_in_ready", longint'(in_ready), 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, longint'(100 + k) * ONE, a);
    chk("t4_buffered", longint'(out_valid), 1);
    pop_log.delete();
    for (int i = 0; i < 60 && pop_log.size() < 10; i++) begin
      step(1'b1, 1'b1, k < 10, 1'b1, 1'b0, longint'(100 + k) * ONE, a);
      if (a) k++;
    end
    chk("t4_total", pop_log.size(), 10);
    for (int i = 0; i < 10 && i < pop_log.size(); i++) chk("t4_order", pop_log[i], 100 + i);

    // en held low with results in flight.
    idle(4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, longint'(200 + i) * ONE, a);
    idle(2, 1'b1, 1'b0);
    idle(5, 1'b0, 1'b0);
    chk("t5_frozen", longint'(out_valid), 0);
    pop_log.delete();
    idle(12, 1'b1, 1'b1);
    chk("t5_count", pop_log.size(), 3);
    for (int i = 0; i < 3 && i < pop_log.size(); i++) chk("t5_order", pop_log[i], 200 + i);

    // Reset with 3 buffered and 4 in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, longint'(300 + i) * ONE, a);
    idle(8, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, longint'(310 + i) * ONE, a);
    idle(1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, a);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready", longint'(in_ready), 1);
    chk("t6_out_valid", longint'(out_valid), 0);
    chk("t6_out_data", longint'(out_data), 0);
    pop_log.delete();
    idle(20, 1'b1, 1'b1);
    chk("t6_no_stale", pop_log.size(), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 199) != 0);
      e    = ($urandom_range(0, 9) < 8);
      iv   = ($urandom_range(0, 9) < 6);
      ordy = $urandom_range(0, 1);
      sclr = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0: yv = rand36();
        1: yv = longint'($urandom_range(0, 2097151)) - 1048576;
        2: yv = (longint'($urandom_range(0, 2000)) - 1000) * ONE + HALF + longint'($urandom_range(0, 2)) - 1;
        3: yv = ($urandom_range(0, 1) != 0) ? YMAX - longint'($urandom_range(0, 3))
                                            : YMIN + longint'($urandom_range(0, 3));
        default: yv = ($urandom_range(0, 1) != 0) ? OMAX * ONE + HALF - 1 + longint'($urandom_range(0, 2))
                                                  : OMIN * ONE - HALF - 1 + longint'($urandom_range(0, 2));
      endcase
      step(r, e, iv, ordy, sclr, yv, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
